if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 130 +++++++++++++
 tb/tb_if_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a halt
// sequencer that lets a fetched halt word drain before fetch stops for good.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned HALT_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  output logic [31:0] IFID_Inst,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [31:0] Fetch_Cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } state_e;

  localparam logic [2:0]  PEND_INIT = HALT_WAIT[2:0];
  localparam logic [5:0]  HALT_OP   = 6'b111111;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [2:0]  pend_cnt_q, pend_cnt_d;

  logic        redirect;
  logic [31:0] target;

  // Branch resolves later in the pipe than jump, so it is the older instruction and wins.
  assign redirect = Br_Taken | Jump;
  assign target   = Br_Taken ? Br_Target : Jump_Target;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    pend_cnt_d   = pend_cnt_q;

    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d         = target;
          ifid_inst_d  = 32'h0000_0000;
          ifid_valid_d = 1'b0;
        end else if (!Stall) begin
          ifid_inst_d  = Imem_Data;
          ifid_pc4_d   = pc_q + 32'd4;
          ifid_valid_d = 1'b1;
          fetch_cnt_d  = fetch_cnt_q + 32'd1;
          if (Imem_Data[31:26] == HALT_OP) begin
            pend_cnt_d = PEND_INIT;
            state_d    = HALT_PEND;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end

      HALT_PEND: begin
        // A redirect here means the halt sat on a mispredicted path.
        if (redirect) begin
          pc_d         = target;
          ifid_inst_d  = 32'h0000_0000;
          ifid_valid_d = 1'b0;
          pend_cnt_d   = 3'd0;
          state_d      = RUN;
        end else if (!Stall) begin
          ifid_inst_d  = 32'h0000_0000;
          ifid_valid_d = 1'b0;
          pend_cnt_d   = pend_cnt_q - 3'd1;
          if (pend_cnt_q == 3'd1) state_d = HALTED;
        end
      end

      HALTED: begin
        ifid_inst_d  = 32'h0000_0000;
        ifid_valid_d = 1'b0;
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_inst_q  <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= 32'h0000_0000;
      pend_cnt_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      pend_cnt_q   <= pend_cnt_d;
    end
  end

  assign Imem_Addr  = pc_q;
  assign IFID_Inst  = ifid_inst_q;
  assign IFID_PC4   = ifid_pc4_q;
  assign IFID_Valid = ifid_valid_q;
  assign Halted     = (state_q == HALTED);
  assign Fetch_Cnt  = fetch_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/stall/redirect/halt scenarios followed by
// randomized traffic, all compared against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          HALT_WAIT = 2;
  localparam logic [31:0] ADDI_W    = 32'h2001_0001;
  localparam logic [31:0] HALT_W    = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_cnt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_valid, m_halted;
  int          m_pend;

  if_stage #(.RESET_PC(RESET_PC), .HALT_WAIT(HALT_WAIT)) dut (
    .Clk(clk), .Rst_n(rst_n), .Stall(stall), .Br_Taken(br_taken),
    .Br_Target(br_target), .Jump(jump), .Jump_Target(jump_target),
    .Imem_Addr(imem_addr), .Imem_Data(imem_data), .IFID_Inst(ifid_inst),
    .IFID_PC4(ifid_pc4), .IFID_Valid(ifid_valid), .Halted(halted),
    .Fetch_Cnt(fetch_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s.imem_addr", tag), imem_addr, m_pc);
    check($sformatf("%s.ifid_inst", tag), ifid_inst, m_inst);
    check($sformatf("%s.ifid_pc4", tag), ifid_pc4, m_pc4);
    check($sformatf("%s.ifid_valid", tag), {31'b0, ifid_valid}, {31'b0, m_valid});
    check($sformatf("%s.halted", tag), {31'b0, halted}, {31'b0, m_halted});
    check($sformatf("%s.fetch_cnt", tag), fetch_cnt, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_inst = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_pend = 0;
  endtask

  task automatic model_bubble();
    m_inst  = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt, input logic [31:0] d);
    logic        redir;
    logic [31:0] tgt;
    redir = b | j;
    tgt   = b ? bt : jt;
    if (m_halted) begin
      model_bubble();
    end else if (m_pend > 0) begin
      if (redir) begin
        m_pc = tgt; model_bubble(); m_pend = 0;
      end else if (!s) begin
        model_bubble();
        m_pend = m_pend - 1;
        if (m_pend == 0) m_halted = 1'b1;
      end
    end else if (redir) begin
      m_pc = tgt; model_bubble();
    end else if (!s) begin
      m_inst = d; m_pc4 = m_pc + 4; m_valid = 1'b1; m_cnt = m_cnt + 1;
      if (d[31:26] == 6'b111111) m_pend = HALT_WAIT;
      else m_pc = m_pc + 4;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input string tag, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic [31:0] d);
    stall = s; br_taken = b; br_target = bt; jump = j; jump_target = jt; imem_data = d;
    model_edge(s, b, bt, j, jt, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ADDI_W);
  endtask

  function automatic logic [31:0] rand_word(input int halt_pct);
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(99) < halt_pct) w[31:26] = 6'b111111;
    else if (w[31:26] == 6'b111111) w[26] = 1'b0;
    return w;
  endfunction

  initial begin
    model_reset();
    #1;
    do_reset("reset");

    // Sequential fetch from RESET_PC.
    run("seq", 3);
    check("seq.pc4_is_12", ifid_pc4, 32'd12);
    check("seq.cnt_is_3", fetch_cnt, 32'd3);
    check("seq.addr_is_12", imem_addr, 32'd12);

    // Two-cycle stall at PC=8.
    @(negedge clk);
    do_reset("reset2");
    run("pre_stall", 2);
    step("stall1", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, ADDI_W);
    step("stall2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, ADDI_W);
    check("stall.pc_held", imem_addr, 32'd8);
    run("resume", 1);
    check("resume.pc4", ifid_pc4, 32'd12);

    // Branch beats jump, and both beat stall.
    step("redir", 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, ADDI_W);
    check("redir.pc_0x40", imem_addr, 32'h40);
    check("redir.cnt_held", fetch_cnt, 32'd3);
    step("jump", 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, ADDI_W);

    // Halt commit at 0x10 with HALT_WAIT=2.
    step("halt_fetch", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, HALT_W);
    check("halt.inst", ifid_inst, HALT_W);
    step("halt_pend_stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, ADDI_W);
    run("halt_drain", 2);
    check("halt.halted", {31'b0, halted}, 32'd1);
    check("halt.pc_0x10", imem_addr, 32'h10);
    step("halted_ignores", 1'b1, 1'b1, 32'h44, 1'b1, 32'h88, ADDI_W);

    // Asynchronous reset mid-cycle while halted.
    #2;
    do_reset("reset_halted");
    check("reset_halted.flag", {31'b0, halted}, 32'd0);

    // Speculative halt squashed by a branch the next cycle.
    step("to_0x10", 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, ADDI_W);
    step("spec_halt", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, HALT_W);
    step("spec_br", 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, ADDI_W);
    check("spec.pc_0x20", imem_addr, 32'h20);
    run("spec_after", 4);
    check("spec.not_halted", {31'b0, halted}, 32'd0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) begin
        #2;
        do_reset("rand_reset");
      end
      step("rand",
           ($urandom_range(99) < 25),
           ($urandom_range(99) < 10), {$urandom, 2'b00} ,
           ($urandom_range(99) < 10), {$urandom, 2'b00},
           rand_word(6));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
